receive_engine: RTL and testbench

RECEIVE_ENGINE -- requirements
Module: receive_engine

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rx_bit_timer.sv | 48 ++++
 rtl/receive_engine.sv | 157 +++++++++++++++
 tb/tb_receive_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// =============================================================================
// Module : uart_pkg
// Desc   : Shared UART engine states, frame-length constants and helpers
// Rev    : 1.0
// =============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } uart_state_t;

    localparam int SHIFT_W       = 10;
    localparam int FRAME_LEN_MIN = 8;
    localparam int FRAME_LEN_MAX = 10;

    // Samples taken after the start bit: data (7/8) + optional parity + stop.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_bit_timer.sv
// =============================================================================
// Module : rx_bit_timer
// Desc   : Bit-time counter, half-bit tick in START, full-bit ticks in DATA
// Rev    : 1.0
// =============================================================================
`default_nettype none

module rx_bit_timer
    import uart_pkg::*;
#(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  uart_state_t       state,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              tick
);

    localparam logic [BAUD_W-1:0] C_ONE = {{(BAUD_W-1){1'b0}}, 1'b1};

    logic [BAUD_W-1:0] cnt;
    logic [BAUD_W-1:0] half_m1;
    logic [BAUD_W-1:0] full_m1;

    assign half_m1 = (baud_k >> 1) - C_ONE;
    assign full_m1 = baud_k - C_ONE;

    always_comb begin
        tick = 1'b0;
        case (state)
            START:   tick = (cnt == half_m1);
            DATA:    tick = (cnt == full_m1);
            default: tick = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state == IDLE || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + C_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/receive_engine.sv
// =============================================================================
// Module : receive_engine
// Desc   : UART receiver with parity, framing and overrun status flags
// Rev    : 1.0
// =============================================================================
`default_nettype none

module receive_engine
    import uart_pkg::*;
#(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RX,
    input  logic [BAUD_W-1:0] BAUD_K,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic              READ,
    output logic [7:0]        RDATA,
    output logic              RX_RDY,
    output logic              PERR,
    output logic              FERR,
    output logic              OVF
);

    uart_state_t          state;
    uart_state_t          state_nxt;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 tick;
    logic [BAUD_W-1:0]    baud_k_l;
    logic                 eight_l;
    logic                 pen_l;
    logic                 ohel_l;
    logic [3:0]           bit_cnt;
    logic [3:0]           len;
    logic                 last_bit;
    logic                 start_frame;
    logic                 final_sample;
    logic                 done;
    logic [SHIFT_W-1:0]   shift_reg;
    logic [SHIFT_W-1:0]   frame;
    logic [7:0]           data_bits;
    logic                 par_rx;
    logic                 par_exp;

    rx_bit_timer #(
        .BAUD_W (BAUD_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .state  (state),
        .baud_k (baud_k_l),
        .tick   (tick)
    );

    assign len      = frame_len(eight_l, pen_l);
    assign last_bit = (bit_cnt == len - 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_frame  = 1'b0;
        final_sample = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s2) begin
                    state_nxt   = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && last_bit) begin
                    state_nxt    = IDLE;
                    final_sample = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stop bit is always the most recent sample, i.e. the MSB before justification.
    assign frame     = shift_reg >> (4'd10 - len);
    assign data_bits = eight_l ? frame[7:0] : {1'b0, frame[6:0]};
    assign par_rx    = eight_l ? frame[8] : frame[7];
    assign par_exp   = (^data_bits) ^ ohel_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            baud_k_l  <= '0;
            eight_l   <= 1'b0;
            pen_l     <= 1'b0;
            ohel_l    <= 1'b0;
            bit_cnt   <= 4'd0;
            shift_reg <= '1;
            done      <= 1'b0;
            RDATA     <= 8'h00;
            RX_RDY    <= 1'b0;
            PERR      <= 1'b0;
            FERR      <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            done  <= final_sample;

            if (start_frame) begin
                baud_k_l <= BAUD_K;
                eight_l  <= EIGHT;
                pen_l    <= PEN;
                ohel_l   <= OHEL;
            end

            if (state != DATA) begin
                bit_cnt <= 4'd0;
            end else if (tick) begin
                shift_reg <= {rx_s2, shift_reg[SHIFT_W-1:1]};
                bit_cnt   <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            end

            if (READ) begin
                RX_RDY <= 1'b0;
                OVF    <= 1'b0;
            end

            // Completion wins over a coincident READ.
            if (done) begin
                RDATA  <= data_bits;
                PERR   <= pen_l & (par_rx != par_exp);
                FERR   <= ~shift_reg[SHIFT_W-1];
                RX_RDY <= 1'b1;
                if (RX_RDY && !READ) begin
                    OVF <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_receive_engine.sv
// =============================================================================
// Module : tb_receive_engine
// Desc   : Scoreboard bench for receive_engine
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_receive_engine;
    import uart_pkg::*;

    localparam int BAUD_W = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              RX;
    logic [BAUD_W-1:0] BAUD_K;
    logic              EIGHT;
    logic              PEN;
    logic              OHEL;
    logic              READ;
    logic [7:0]        RDATA;
    logic              RX_RDY;
    logic              PERR;
    logic              FERR;
    logic              OVF;

    receive_engine #(
        .BAUD_W (BAUD_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .RX     (RX),
        .BAUD_K (BAUD_K),
        .EIGHT  (EIGHT),
        .PEN    (PEN),
        .OHEL   (OHEL),
        .READ   (READ),
        .RDATA  (RDATA),
        .RX_RDY (RX_RDY),
        .PERR   (PERR),
        .FERR   (FERR),
        .OVF    (OVF)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
        int         start_cyc;
        bit         chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   model_rdy = 1'b0;
    bit   model_ovf = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Completion is visible as a rising RX_RDY, or a rising OVF on overrun.
    logic prev_rdy = 1'b0;
    logic prev_ovf = 1'b0;
    exp_t mon_e;
    int   mon_lat;
    always @(negedge clk) begin
        if (!reset && ((RX_RDY && !prev_rdy) || (OVF && !prev_ovf))) begin
            if (sb.size() == 0) begin
                check_val("unexpected_frame", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("rdata",  {24'd0, RDATA}, {24'd0, mon_e.data});
                check_val("rx_rdy", {31'd0, RX_RDY}, 32'd1);
                check_val("perr",   {31'd0, PERR}, {31'd0, mon_e.perr});
                check_val("ferr",   {31'd0, FERR}, {31'd0, mon_e.ferr});
                check_val("ovf",    {31'd0, OVF},  {31'd0, mon_e.ovf});
                if (mon_e.chk_lat) begin
                    mon_lat = cyc - mon_e.start_cyc;
                    if (mon_lat < 155 || mon_lat > 157)
                        $display("latency observed %0d cycles", mon_lat);
                    check_val("latency_window", {31'd0, (mon_lat >= 155 && mon_lat <= 157)}, 32'd1);
                end
            end
        end
        prev_rdy <= RX_RDY;
        prev_ovf <= OVF;
    end

    task automatic drive_bits(input logic [10:0] bits, input int n, input int k);
        for (int i = 0; i < n; i++) begin
            RX = bits[i];
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic bad_par,
                              input logic stop, input bit chk_lat);
        logic [10:0] v;
        logic [7:0]  d;
        logic        par;
        int          idx;
        exp_t        e;
        d   = EIGHT ? data : {1'b0, data[6:0]};
        par = (^d) ^ OHEL ^ bad_par;
        v   = '1;
        v[0] = 1'b0;
        idx = 1;
        for (int i = 0; i < (EIGHT ? 8 : 7); i++) begin
            v[idx] = d[i];
            idx++;
        end
        if (PEN) begin
            v[idx] = par;
            idx++;
        end
        v[idx] = stop;
        idx++;
        e.data      = d;
        e.perr      = PEN & bad_par;
        e.ferr      = ~stop;
        e.ovf       = model_ovf | model_rdy;
        e.start_cyc = cyc;
        e.chk_lat   = chk_lat;
        model_rdy   = 1'b1;
        model_ovf   = e.ovf;
        sb.push_back(e);
        drive_bits(v, idx, int'(BAUD_K));
        RX = 1'b1;
        repeat (2 * int'(BAUD_K)) @(posedge clk);
        #1;
        check_val("frame_done", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic do_read();
        READ = 1'b1;
        @(posedge clk);
        #1;
        READ = 1'b0;
        model_rdy = 1'b0;
        model_ovf = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        @(negedge clk);
        check_val({tag, "_rdata"}, {24'd0, RDATA}, 32'd0);
        check_val({tag, "_rdy"},   {31'd0, RX_RDY}, 32'd0);
        check_val({tag, "_flags"}, {29'd0, PERR, FERR, OVF}, 32'd0);
        check_val({tag, "_state"}, {30'd0, dut.state}, {30'd0, IDLE});
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        RX     = 1'b1;
        READ   = 1'b0;
        EIGHT  = 1'b1;
        PEN    = 1'b0;
        OHEL   = 1'b0;
        BAUD_K = 19'd16;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 with completion latency
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        do_read();

        // 7E1, wrong then correct parity
        EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b0;
        send_frame(8'h41, 1'b1, 1'b1, 1'b0);
        do_read();
        send_frame(8'h41, 1'b0, 1'b1, 1'b0);
        do_read();

        // 8O1, stop bit low
        EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b1;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        do_read();

        // overrun
        PEN = 1'b0; OHEL = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        do_read();
        @(negedge clk);
        check_val("read_rdy", {31'd0, RX_RDY}, 32'd0);
        check_val("read_ovf", {31'd0, OVF}, 32'd0);
        @(posedge clk);
        #1;

        // 5-clock glitch is a false start
        RX = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_val("glitch_rdy", {31'd0, RX_RDY}, 32'd0);
        check_val("glitch_state", {30'd0, dut.state}, {30'd0, IDLE});
        @(posedge clk);
        #1;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);

        // reset in data bit 4, leaving the 0x3C frame unread
        drive_bits({2'b11, 8'h99, 1'b0}, 5, 16);
        RX = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_rdy = 1'b0;
        model_ovf = 1'b0;
        check_cleared("midreset");
        repeat (40) @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        do_read();

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
